// File: rtl/pipe_mem.sv
// pipe_mem: unified byte-addressed big-endian memory for the MIPS pipeline.
// Read-only I-port for fetch and a D-port for loads/stores. Both ports return
// registered results one cycle after an accepted request. A clear engine zeroes
// the array after reset before requests are accepted.
module pipe_mem #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter bit          CLR_ON_RST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ready,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  output logic        i_fault,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_sext,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_fault
);

  localparam int unsigned NWORDS   = DEPTH_BYTES / 4;
  localparam int unsigned WAW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH_BYTES);
  localparam logic [WAW-1:0] LAST_PTR = WAW'(NWORDS - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  state_e         state_q;
  logic [WAW-1:0] clr_ptr_q;
  logic           ready_q;

  // Word-organised storage; byte lane at bits [31:24] is the lowest address.
  logic [31:0] mem_q [NWORDS];

  logic           i_acc, d_acc;
  logic           i_flt, d_flt, d_mis;
  logic [WAW-1:0] i_widx, d_widx;
  logic           d_st;
  logic [3:0]     st_be, wr_be, i_byp;
  logic [31:0]    st_word;
  logic [31:0]    i_old, i_word;
  logic [31:0]    d_old, d_shift, d_ld;

  logic [31:0] i_rdata_q, i_rdata_d;
  logic        i_valid_q, i_valid_d;
  logic        i_fault_q, i_fault_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_valid_q, d_valid_d;
  logic        d_fault_q, d_fault_d;

  assign i_acc  = i_req & ready_q;
  assign d_acc  = d_req & ready_q;
  assign i_widx = i_addr[WAW+1:2];
  assign d_widx = d_addr[WAW+1:2];

  // Access checks. Since DEPTH_BYTES is a multiple of 4, an aligned access whose
  // start address is in range also ends in range, so one start compare suffices.
  always_comb begin
    unique case (d_size)
      2'b00:   d_mis = 1'b0;
      2'b01:   d_mis = d_addr[0];
      2'b10:   d_mis = |d_addr[1:0];
      default: d_mis = 1'b1;
    endcase
    d_flt = d_mis | (d_addr >= DEPTH_W);
    i_flt = (|i_addr[1:0]) | (i_addr >= DEPTH_W);
  end

  // Store lane enables/data: byte/half data is replicated across lanes and the
  // enable mask picks the lanes that are actually written.
  always_comb begin
    st_be   = '0;
    st_word = '0;
    unique case (d_size)
      2'b00: begin
        st_be   = 4'b1000 >> d_addr[1:0];
        st_word = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = d_addr[1] ? 4'b0011 : 4'b1100;
        st_word = {2{d_wdata[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b1111;
        st_word = d_wdata;
      end
      default: begin
        st_be   = '0;
        st_word = '0;
      end
    endcase
    d_st  = d_acc & d_we & ~d_flt & rst_n;
    wr_be = st_be & {4{d_st}};
  end

  // Fetch path with write-first bypass of lanes stored in the same cycle.
  always_comb begin
    i_old  = mem_q[i_widx];
    i_byp  = (d_widx == i_widx) ? wr_be : 4'b0000;
    i_word = i_old;
    for (int unsigned b = 0; b < 4; b++) begin
      if (i_byp[b]) i_word[8*b +: 8] = st_word[8*b +: 8];
    end
  end

  // Load path: shift the addressed byte/half to the top, then right-justify and extend.
  always_comb begin
    d_old   = mem_q[d_widx];
    d_shift = d_old << {d_addr[1:0], 3'b000};
    unique case (d_size)
      2'b00:   d_ld = {{24{d_sext & d_shift[31]}}, d_shift[31:24]};
      2'b01:   d_ld = {{16{d_sext & d_shift[31]}}, d_shift[31:16]};
      default: d_ld = d_old;
    endcase
  end

  // Next values of the registered outputs; data/fault hold when nothing is accepted.
  always_comb begin
    i_valid_d = i_acc;
    i_rdata_d = i_rdata_q;
    i_fault_d = i_fault_q;
    d_valid_d = d_acc;
    d_rdata_d = d_rdata_q;
    d_fault_d = d_fault_q;
    if (i_acc) begin
      i_rdata_d = i_flt ? '0 : i_word;
      i_fault_d = i_flt;
    end
    if (d_acc) begin
      d_rdata_d = (d_we | d_flt) ? '0 : d_ld;
      d_fault_d = d_flt;
    end
  end

  // Clear-then-ready sequencer; ready rises on the edge that clears the last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLR_ON_RST ? S_CLEAR : S_READY;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_PTR) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
          end
        end
        S_READY: ready_q <= 1'b1;
        default: state_q <= S_READY;
      endcase
    end
  end

  // Array update: clear engine owns the array until ready, then stores write lanes.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == S_CLEAR)) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[d_widx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end

  // Output registers; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      i_valid_q <= 1'b0;
      i_fault_q <= 1'b0;
      d_rdata_q <= '0;
      d_valid_q <= 1'b0;
      d_fault_q <= 1'b0;
    end else begin
      i_rdata_q <= i_rdata_d;
      i_valid_q <= i_valid_d;
      i_fault_q <= i_fault_d;
      d_rdata_q <= d_rdata_d;
      d_valid_q <= d_valid_d;
      d_fault_q <= d_fault_d;
    end
  end

  assign ready   = ready_q;
  assign i_rdata = i_rdata_q;
  assign i_valid = i_valid_q;
  assign i_fault = i_fault_q;
  assign d_rdata = d_rdata_q;
  assign d_valid = d_valid_q;
  assign d_fault = d_fault_q;

endmodule

// File: tb/tb_pipe_mem.sv
// tb_pipe_mem: scoreboard bench for pipe_mem with a 64-byte array.
// A byte-array reference model produces expected results at issue time;
// they are queued per port and compared when the DUT presents valid.
module tb_pipe_mem;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        i_fault;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_sext;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_fault;

  always #5 clk = ~clk;

  pipe_mem #(
    .DEPTH_BYTES(DEPTH),
    .CLR_ON_RST (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ready  (ready),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_rdata(i_rdata),
    .i_valid(i_valid),
    .i_fault(i_fault),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_size (d_size),
    .d_sext (d_sext),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .d_fault(d_fault)
  );

  logic [7:0]  mem_m [DEPTH];
  logic [32:0] iq[$];
  logic [32:0] dq[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          mdl_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference read: returns {fault, data}; big-endian byte array.
  function automatic logic [32:0] mdl_read(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sx);
    int unsigned n;
    logic [32:0] last;
    logic [31:0] v;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    last = {1'b0, a} + 33'(n) - 33'd1;
    if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
        last >= 33'(DEPTH))
      return {1'b1, 32'h0};
    v = '0;
    for (int unsigned k = 0; k < n; k++) v = {v[23:0], mem_m[int'(a) + int'(k)]};
    if (sx && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (sx && n == 2) v = {{16{v[15]}}, v[15:0]};
    return {1'b0, v};
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int unsigned k = 0; k < n; k++) mem_m[int'(a) + int'(k)] = wd[8*(n-1-k) +: 8];
  endtask

  task automatic tick();
    logic [32:0] e;
    @(posedge clk);
    #1;
    chk("i_valid", 32'(i_valid), 32'(iq.size() != 0));
    if (iq.size() != 0) begin
      e = iq.pop_front();
      if (i_valid) begin
        chk("i_rdata", i_rdata, e[31:0]);
        chk("i_fault", 32'(i_fault), 32'(e[32]));
      end
    end
    chk("d_valid", 32'(d_valid), 32'(dq.size() != 0));
    if (dq.size() != 0) begin
      e = dq.pop_front();
      if (d_valid) begin
        chk("d_rdata", d_rdata, e[31:0]);
        chk("d_fault", 32'(d_fault), 32'(e[32]));
      end
    end
  endtask

  // Drive one cycle of requests on both ports and queue expectations.
  task automatic issue(input bit ir, input logic [31:0] ia, input bit dr, input bit we,
                       input logic [1:0] sz, input bit sx, input logic [31:0] da,
                       input logic [31:0] wd);
    logic [32:0] r;
    bit acc;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = we; d_size = sz; d_sext = sx; d_addr = da; d_wdata = wd;
    acc = mdl_ready && (rst_n == 1'b1);
    if (acc && dr) begin
      r = mdl_read(da, sz, sx);
      if (we) begin
        if (!r[32]) mdl_store(da, sz, wd);
        dq.push_back({r[32], 32'h0});
      end else begin
        dq.push_back(r);
      end
    end
    if (acc && ir) iq.push_back(mdl_read(ia, 2'b10, 1'b0));
    tick();
  endtask

  task automatic idle();
    issue(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask
  task automatic fe(input logic [31:0] a);
    issue(1'b1, a, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
  endtask
  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input bit sx);
    issue(1'b0, '0, 1'b1, 1'b0, sz, sx, a, '0);
  endtask
  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    issue(1'b0, '0, 1'b1, 1'b1, sz, 1'b0, a, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [1:0] sz;
    logic [31:0] a;
    for (int unsigned k = 0; k < DEPTH; k++) mem_m[k] = 8'h00;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_sext = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    idle();
    idle();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_i_fault", 32'(i_fault), 32'd0);
    chk("rst_d_fault", 32'(d_fault), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);

    // Clear phase: 16 cycles, requests ignored
    rst_n = 1'b1;
    for (int unsigned c = 1; c <= 16; c++) begin
      issue(1'b1, 32'h3C, 1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, '0);
      chk("ready_clr", 32'(ready), 32'(c == 16));
    end
    mdl_ready = 1'b1;
    fe(32'h3C);
    ld(32'h3C, 2'b10, 1'b0);

    // Word store, byte and half loads
    st(32'h10, 2'b10, 32'h11223344);
    for (int unsigned k = 0; k < 4; k++) ld(32'h10 + k, 2'b00, 1'b0);
    ld(32'h12, 2'b01, 1'b0);
    st(32'h11, 2'b00, 32'h000000AB);
    ld(32'h10, 2'b10, 1'b0);

    // Sign extension
    st(32'h20, 2'b00, 32'h00000080);
    ld(32'h20, 2'b00, 1'b1);
    ld(32'h20, 2'b01, 1'b1);

    // Faults and range edges
    ld(32'h02, 2'b10, 1'b0);
    st(32'h21, 2'b01, 32'h0000BEEF);
    ld(32'h20, 2'b01, 1'b0);
    fe(32'h40);
    fe(32'h02);
    ld(32'h3F, 2'b00, 1'b0);
    ld(32'h3E, 2'b01, 1'b1);
    ld(32'h3D, 2'b01, 1'b0);
    ld(32'h40, 2'b00, 1'b0);
    ld(32'h80000010, 2'b10, 1'b0);
    ld(32'h10, 2'b11, 1'b0);
    st(32'h3C, 2'b10, 32'hCAFEF00D);
    ld(32'h3C, 2'b10, 1'b0);
    ld(32'h3E, 2'b01, 1'b1);

    // Same-cycle store/fetch collisions (write-first)
    issue(1'b1, 32'h08, 1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
    issue(1'b1, 32'h0C, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AA);
    issue(1'b1, 32'h0C, 1'b1, 1'b1, 2'b01, 1'b0, 32'h0E, 32'h00001234);
    fe(32'h0C);

    // Back-to-back traffic on both ports
    for (int unsigned k = 0; k < 8; k++)
      issue(1'b1, 32'(4 * k), 1'b1, 1'b1, 2'b10, 1'b0, 32'h30 + 32'(4 * (k % 4)), $urandom);
    for (int unsigned k = 0; k < 12; k++) begin
      sz = 2'(k % 3);
      a  = 32'h30 + 32'((4 * k) % 16);
      if (sz == 2'b00) a = a + 32'(k % 4);
      if (sz == 2'b01) a = a + 32'(2 * (k % 2));
      issue(1'b1, 32'h30 + 32'(4 * (k % 4)), 1'b1, 1'b0, sz, k[0], a, '0);
    end
    idle();

    // Reset mid-stream: in-flight load dropped, array re-cleared
    st(32'h04, 2'b10, 32'h12345678);
    rst_n = 1'b0;
    mdl_ready = 1'b0;
    issue(1'b1, 32'h04, 1'b1, 1'b0, 2'b10, 1'b0, 32'h04, '0);
    chk("ready_in_rst", 32'(ready), 32'd0);
    idle();
    rst_n = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) mem_m[k] = 8'h00;
    n = 0;
    while (!ready && n < 40) begin
      idle();
      n++;
    end
    chk("reclear_cycles", n, 32'd16);
    mdl_ready = 1'b1;
    ld(32'h04, 2'b10, 1'b0);
    ld(32'h10, 2'b10, 1'b0);
    fe(32'h08);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
